// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, and a
// first-word-fall-through FIFO with sticky overflow.
module uart_rx_fifo #(
  parameter int CLK_FREQ     = 25000000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int BUFFER_SIZE  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          read,
  output logic [PAYLOAD_BITS-1:0]       data_out,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(BUFFER_SIZE):0]  count,
  output logic                          frame_error,
  output logic                          overflow
);

  localparam int CYCLES_PER_BIT = CLK_FREQ / BIT_RATE;
  localparam int HALF           = CYCLES_PER_BIT / 2;
  localparam int CW             = $clog2(CYCLES_PER_BIT + 1);
  localparam int BW             = $clog2(PAYLOAD_BITS + 1);
  localparam int AW             = $clog2(BUFFER_SIZE);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [BW-1:0]           bit_idx, bit_idx_n;
  logic [PAYLOAD_BITS-1:0] shreg, shreg_n;
  logic                    rx_meta, rx_sync;
  logic                    push;

  logic [PAYLOAD_BITS-1:0] mem [BUFFER_SIZE];
  logic [AW-1:0]           wptr, rptr;
  logic                    do_read, do_push;

  // Synchronizer resets to idle-high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 1'b1;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    push        = 1'b0;
    frame_error = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_sync) state_n = START;
      end
      // Re-check the line at mid start bit to reject short glitches
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          state_n = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_sync, shreg[PAYLOAD_BITS-1:1]};
          if (bit_idx == IDX_LAST) begin
            bit_idx_n = '0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_sync) push = 1'b1;
          else         frame_error = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A read frees a slot in the same cycle, so a full FIFO can still accept a push
  assign do_read  = read & ~rx_empty;
  assign do_push  = push & (~rx_full | do_read);
  assign rx_empty = (count == '0);
  assign rx_full  = (count == (AW+1)'(BUFFER_SIZE));
  assign data_out = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_read) rptr <= rptr + 1'b1;
      case ({do_push, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random frames
// compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int CPB      = 25000000 / 115200;
  localparam int PUSH_CYC = 10 * CPB - 107;
  localparam int DEPTH    = 8;

  logic       clk = 1'b0;
  logic       reset, rx, read;
  logic [7:0] data_out;
  logic       rx_empty, rx_full, frame_error, overflow;
  logic [3:0] count;

  logic [7:0] modelQ[$];
  bit         modelOvf;
  int         errors = 0;
  int         checks = 0;
  int         feCount = 0;

  uart_rx_fifo dut (
    .clk(clk), .reset(reset), .rx(rx), .read(read),
    .data_out(data_out), .rx_empty(rx_empty), .rx_full(rx_full),
    .count(count), .frame_error(frame_error), .overflow(overflow)
  );

  always #20 clk = ~clk;

  always @(negedge clk) if (frame_error === 1'b1) feCount++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, " count"}, 32'(count), 32'(modelQ.size()));
    checkOutput({tag, " rx_empty"}, 32'(rx_empty), 32'(modelQ.size() == 0));
    checkOutput({tag, " rx_full"}, 32'(rx_full), 32'(modelQ.size() == DEPTH));
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(modelOvf));
    if (modelQ.size() != 0) checkOutput({tag, " head"}, 32'(data_out), 32'(modelQ[0]));
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    read  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    modelQ.delete();
    modelOvf = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Drives one frame cycle by cycle; optional read pulse and mid-frame reset
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int readCycle,
                               input int abortCycle, input bit checkLatency);
    int         feBefore = feCount;
    int         fallAt   = -1;
    bit         wasEmpty = (modelQ.size() == 0);
    logic [9:0] frame    = {stopBit, data, 1'b0};
    int         pos;
    for (int n = 0; n < 10 * CPB + 20; n++) begin
      @(negedge clk);
      if (fallAt < 0 && n > 0 && rx_empty == 1'b0) fallAt = n;
      if (n == abortCycle) begin
        applyReset();
        checkOutput("abort frame_error", 32'(feCount - feBefore), 32'd0);
        return;
      end
      pos = n / CPB;
      if (pos < 9) rx = frame[pos];
      else if (pos == 9) rx = (stopBit || (n - 9 * CPB) >= 130) ? 1'b1 : 1'b0;
      else rx = 1'b1;
      read = (n == readCycle);
    end
    read = 1'b0;
    if (readCycle >= 0 && modelQ.size() != 0) void'(modelQ.pop_front());
    if (stopBit) begin
      if (modelQ.size() < DEPTH) modelQ.push_back(data);
      else modelOvf = 1'b1;
    end
    checkOutput("frame_error pulses", 32'(feCount - feBefore), stopBit ? 32'd0 : 32'd1);
    if (checkLatency && wasEmpty && stopBit)
      checkOutput("rx_empty fall latency ok", 32'(fallAt >= 2060 && fallAt <= 2066), 32'd1);
  endtask

  task automatic readOne(input string tag);
    @(negedge clk);
    if (modelQ.size() != 0) checkOutput({tag, " data"}, 32'(data_out), 32'(modelQ[0]));
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    if (modelQ.size() != 0) void'(modelQ.pop_front());
    checkState(tag);
  endtask

  initial begin
    int         feSnap;
    logic [7:0] d;
    logic       s;
    int         rc;
    rx = 1'b1; read = 1'b0; reset = 1'b0;
    applyReset();
    checkState("reset");

    applyStimulus(8'h4A, 1'b1, -1, -1, 1'b1);
    checkState("frame 4A");
    readOne("read 4A");
    readOne("read empty");

    feSnap = feCount;
    @(negedge clk); rx = 1'b0;
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    checkState("glitch");
    checkOutput("glitch frame_error", 32'(feCount - feSnap), 32'd0);

    applyStimulus(8'h55, 1'b0, -1, -1, 1'b0);
    checkState("bad stop");

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(8'(i), 1'b1, -1, -1, 1'b0);
      checkState("fill");
    end
    applyStimulus(8'h08, 1'b1, PUSH_CYC, -1, 1'b0);
    checkState("push+read while full");
    applyStimulus(8'h09, 1'b1, -1, -1, 1'b0);
    checkState("overflow");
    for (int i = 0; i < DEPTH; i++) readOne("drain");

    applyStimulus(8'hC3, 1'b1, -1, 5 * CPB + 100, 1'b0);
    checkState("after abort");
    applyStimulus(8'hA5, 1'b1, -1, -1, 1'b1);
    checkState("frame A5");
    readOne("read A5");

    repeat (8) begin
      d  = 8'($urandom);
      s  = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 3) == 0) ? PUSH_CYC : -1;
      applyStimulus(d, s, rc, -1, 1'b1);
      checkState("random frame");
      repeat ($urandom_range(0, 2)) readOne("random read");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
